weight_fetch_sched: RTL and testbench

//  Sequencer/arbiter in front of the single-port weight buffer SRAM. Takes one fetch

---
 rtl/npu_pkg.sv | 5 +
 rtl/npu_sync_fifo.sv | 48 ++++
 rtl/weight_fetch_sched.sv | 178 +++++++++++++++++
 tb/tb_weight_fetch_sched.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared state type and buffer timing constant for the weight path
package npu_pkg;
  typedef enum logic [1:0] {WF_IDLE, WF_FETCH, WF_DRAIN, WF_DONE} wf_state_e;
  localparam int WBUF_RD_LATENCY = 2;
endpackage

// File: rtl/npu_sync_fifo.sv
// rtl/npu_sync_fifo.sv - synchronous FIFO with occupancy count, async active-low reset
module npu_sync_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign do_push = push & (count != FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/weight_fetch_sched.sv
// rtl/weight_fetch_sched.sv - weight buffer read sequencer / DMA write arbiter
// Optional perf counters: define WEIGHT_FETCH_PERF_EN.
module weight_fetch_sched
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 14,
  parameter int LEN_WIDTH    = 14,
  parameter int REP_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int RD_BURST_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [REP_WIDTH-1:0]  cmd_repeat,
  input  logic                  dma_wr_valid,
  output logic                  dma_wr_ready,
  input  logic [ADDR_WIDTH-1:0] dma_wr_addr,
  input  logic [DATA_WIDTH-1:0] dma_wr_data,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [DATA_WIDTH-1:0] buf_wr_data,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  input  logic                  buf_rd_valid,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_last,
  output logic                  busy,
`ifdef WEIGHT_FETCH_PERF_EN
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_wr_preempt,
`endif
  output logic                  done
);
  localparam int OW   = $clog2(WBUF_RD_LATENCY + 1);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int SW   = $clog2(RD_BURST_MAX + 1);
  localparam int SUMW = ((OW > CW) ? OW : CW) + 1;
  localparam logic [SUMW-1:0] DEPTH_C = SUMW'(FIFO_DEPTH);
  localparam logic [SW-1:0]   BURST_C = SW'(RD_BURST_MAX);

  wf_state_e                  state;
  logic [ADDR_WIDTH-1:0]      base_q;
  logic [LEN_WIDTH-1:0]       len_q, offset;
  logic [REP_WIDTH-1:0]       passes_q, pass_q;
  logic [OW-1:0]              outstanding;
  logic [WBUF_RD_LATENCY-1:0] tag_sr;
  logic [SW-1:0]              rd_streak;
  logic [CW-1:0]              fifo_count;
  logic                       fifo_empty;
  logic [DATA_WIDTH:0]        fifo_head;
  logic                       accept, credit, read_req, last_read, ret_valid, pop;

  assign accept    = cmd_valid & cmd_ready;
  assign credit    = (SUMW'(outstanding) + SUMW'(fifo_count)) < DEPTH_C;
  assign read_req  = (state == WF_FETCH) & credit;
  assign last_read = (offset == len_q - LEN_WIDTH'(1)) & (pass_q == passes_q - REP_WIDTH'(1));

  assign dma_wr_ready = dma_wr_valid & (~read_req | (rd_streak >= BURST_C));
  assign buf_wr_en    = dma_wr_valid & dma_wr_ready;
  assign buf_wr_addr  = dma_wr_addr;
  assign buf_wr_data  = dma_wr_data;
  assign buf_rd_en    = read_req & ~buf_wr_en;
  assign buf_rd_addr  = base_q + ADDR_WIDTH'(offset);

  // Returns arriving with nothing outstanding belong to a command killed by reset.
  assign ret_valid = buf_rd_valid & (outstanding != '0);
  assign w_valid   = ~fifo_empty;
  assign w_data    = fifo_head[DATA_WIDTH-1:0];
  assign w_last    = fifo_head[DATA_WIDTH];
  assign pop       = w_valid & w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WF_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      passes_q  <= '0;
      offset    <= '0;
      pass_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        WF_IDLE: if (accept) begin
          base_q    <= cmd_base;
          len_q     <= cmd_len;
          passes_q  <= (cmd_repeat == '0) ? REP_WIDTH'(1) : cmd_repeat;
          offset    <= '0;
          pass_q    <= '0;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          if (cmd_len == '0) begin
            state <= WF_DONE;
            done  <= 1'b1;
          end else begin
            state <= WF_FETCH;
          end
        end
        WF_FETCH: if (buf_rd_en) begin
          if (offset == len_q - LEN_WIDTH'(1)) begin
            offset <= '0;
            pass_q <= pass_q + 1'b1;
          end else begin
            offset <= offset + 1'b1;
          end
          if (last_read) state <= WF_DRAIN;
        end
        WF_DRAIN: if (outstanding == '0 && fifo_empty) begin
          state <= WF_DONE;
          done  <= 1'b1;
        end
        default: begin
          state     <= WF_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      tag_sr      <= '0;
      rd_streak   <= '0;
    end else begin
      case ({buf_rd_en, ret_valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      tag_sr <= {tag_sr[WBUF_RD_LATENCY-2:0], buf_rd_en & last_read};
      if (!dma_wr_valid || buf_wr_en) rd_streak <= '0;
      else if (buf_rd_en && rd_streak != BURST_C) rd_streak <= rd_streak + 1'b1;
    end
  end

  npu_sync_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ret_valid),
    .push_data({tag_sr[WBUF_RD_LATENCY-1], buf_rd_data}),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

`ifdef WEIGHT_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_wr_preempt   <= '0;
    end else if (accept) begin
      perf_stall_cycles <= '0;
      perf_wr_preempt   <= '0;
    end else begin
      if (busy && w_valid && !w_ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (buf_wr_en && read_req && perf_wr_preempt != '1)
        perf_wr_preempt <= perf_wr_preempt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_weight_fetch_sched.sv
// tb/tb_weight_fetch_sched.sv - directed self-checking bench for weight_fetch_sched
module tb_weight_fetch_sched;
  localparam int DW = 128;
  localparam int AW = 14;
  localparam int LW = 14;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_base = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [RW-1:0] cmd_repeat = '0;
  logic          dma_wr_valid = 1'b0, dma_wr_ready;
  logic [AW-1:0] dma_wr_addr = '0;
  logic [DW-1:0] dma_wr_data = '0;
  logic          buf_wr_en, buf_rd_en, buf_rd_valid;
  logic [AW-1:0] buf_wr_addr, buf_rd_addr;
  logic [DW-1:0] buf_wr_data, buf_rd_data;
  logic          w_valid, w_ready = 1'b0, w_last, busy, done;
  logic [DW-1:0] w_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int both_en = 0;

  weight_fetch_sched dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
    .cmd_len(cmd_len), .cmd_repeat(cmd_repeat),
    .dma_wr_valid(dma_wr_valid), .dma_wr_ready(dma_wr_ready),
    .dma_wr_addr(dma_wr_addr), .dma_wr_data(dma_wr_data),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data), .buf_rd_valid(buf_rd_valid),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {8{2'b10, a}};
  endfunction

  // Buffer model: fixed two-cycle read latency, contents derived from address.
  logic p1 = 1'b0, p2 = 1'b0;
  logic [AW-1:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    p1 <= buf_rd_en; a1 <= buf_rd_addr;
    p2 <= p1;        a2 <= a1;
  end
  assign buf_rd_valid = p2;
  assign buf_rd_data  = word_of(a2);

  logic [AW-1:0] rd_log[$];
  int            rd_cyc[$];
  logic [DW-1:0] wd_log[$];
  logic          wl_log[$];
  int            pop_cyc[$];
  int            done_cyc[$];
  int            ev_log[$];

  always @(negedge clk) if (rst_n) begin
    if (buf_rd_en) begin rd_log.push_back(buf_rd_addr); rd_cyc.push_back(cyc); end
    if (w_valid && w_ready) begin
      wd_log.push_back(w_data); wl_log.push_back(w_last); pop_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (buf_rd_en && buf_wr_en) both_en++;
    ev_log.push_back(buf_rd_en ? 1 : (buf_wr_en ? 2 : 0));
  end

  task automatic clear_logs;
    rd_log.delete(); rd_cyc.delete(); wd_log.delete(); wl_log.delete();
    pop_cyc.delete(); done_cyc.delete(); ev_log.delete();
  endtask

  task automatic issue_cmd(input logic [AW-1:0] b, input logic [LW-1:0] l, input logic [RW-1:0] r);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_base = b; cmd_len = l; cmd_repeat = r; acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done_cyc.size() == 0 && n < budget) begin @(posedge clk); n++; end
    ok = (done_cyc.size() != 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done, w_valid, w_last, buf_rd_en, buf_wr_en, dma_wr_ready} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 10000000",
               {cmd_ready, busy, done, w_valid, w_last, buf_rd_en, buf_wr_en, dma_wr_ready});
    end
    checks++;
    if (w_data !== '0 || buf_rd_addr !== '0) begin
      failures++; $display("FAIL reset_data: got w_data=%0h rd_addr=%0h expected 0", w_data, buf_rd_addr);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_release: got ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic;
    bit ok;
    logic [AW-1:0] a;
    w_ready = 1'b1;
    clear_logs();
    issue_cmd(14'h10, 14'd4, 8'd1);
    wait_done(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout: got no done expected done pulse"); end
    checks++;
    if (rd_log.size() != 4 || rd_cyc[0] != acc_cyc + 1 || rd_cyc[3] != acc_cyc + 4) begin
      failures++; $display("FAIL basic_rd_timing: got n=%0d first=%0d expected n=4 first=%0d back-to-back",
                           rd_log.size(), rd_cyc[0], acc_cyc + 1);
    end
    for (int i = 0; i < 4; i++) begin
      a = AW'(32'h10 + i);
      checks++;
      if (i >= rd_log.size() || rd_log[i] !== a || i >= wd_log.size() ||
          wd_log[i] !== word_of(a) || wl_log[i] !== (i == 3)) begin
        failures++; $display("FAIL basic_word%0d: got addr=%0h last=%b expected addr=%0h last=%b",
                             i, rd_log[i], wl_log[i], a, i == 3);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || pop_cyc.size() != 4 || done_cyc[0] != pop_cyc[3] + 2) begin
      failures++; $display("FAIL basic_done: got pulses=%0d at %0d expected 1 at %0d",
                           done_cyc.size(), done_cyc[0], pop_cyc[3] + 2);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [AW-1:0] a;
    clear_logs();
    issue_cmd(14'h3FFE, 14'd4, 8'd0);
    wait_done(100, ok);
    checks++;
    if (!ok || rd_log.size() != 4 || wd_log.size() != 4) begin
      failures++; $display("FAIL wrap_count: got rd=%0d words=%0d expected 4 4", rd_log.size(), wd_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      a = AW'(32'h3FFE + i);
      checks++;
      if (rd_log[i] !== a || wd_log[i] !== word_of(a) || wl_log[i] !== (i == 3)) begin
        failures++; $display("FAIL wrap_addr%0d: got %0h expected %0h", i, rd_log[i], a);
      end
    end
  endtask

  task automatic test_repeat;
    bit ok;
    logic [AW-1:0] a;
    clear_logs();
    issue_cmd(14'h100, 14'd3, 8'd2);
    wait_done(100, ok);
    checks++;
    if (!ok || wd_log.size() != 6 || done_cyc.size() != 1) begin
      failures++; $display("FAIL repeat_count: got words=%0d done=%0d expected 6 1", wd_log.size(), done_cyc.size());
    end
    for (int i = 0; i < 6; i++) begin
      a = AW'(32'h100 + (i % 3));
      checks++;
      if (rd_log[i] !== a || wd_log[i] !== word_of(a) || wl_log[i] !== (i == 5)) begin
        failures++; $display("FAIL repeat_word%0d: got addr=%0h last=%b expected addr=%0h last=%b",
                             i, rd_log[i], wl_log[i], a, i == 5);
      end
    end
  endtask

  task automatic test_stall;
    bit ok;
    int bad;
    logic [DW-1:0] held;
    logic [AW-1:0] a;
    w_ready = 1'b0;
    clear_logs();
    issue_cmd(14'h200, 14'd16, 8'd1);
    repeat (10) @(negedge clk);
    held = w_data;
    repeat (10) @(negedge clk);
    checks++;
    if (rd_log.size() != 4 || wd_log.size() != 0 || w_valid !== 1'b1) begin
      failures++; $display("FAIL stall_credit: got reads=%0d pops=%0d valid=%b expected 4 0 1",
                           rd_log.size(), wd_log.size(), w_valid);
    end
    checks++;
    if (w_data !== held || w_data !== word_of(14'h200)) begin
      failures++; $display("FAIL stall_hold: got %0h expected %0h", w_data, word_of(14'h200));
    end
    @(posedge clk); #1 w_ready = 1'b1;
    wait_done(200, ok);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      a = AW'(32'h200 + i);
      if (i >= wd_log.size() || wd_log[i] !== word_of(a) || wl_log[i] !== (i == 15)) bad++;
    end
    checks++;
    if (!ok || wd_log.size() != 16 || bad != 0) begin
      failures++; $display("FAIL stall_resume: got words=%0d bad=%0d expected 16 0", wd_log.size(), bad);
    end
  endtask

  task automatic test_dma_arb;
    bit ok;
    int first, last, run, nw, idle, bad;
    logic [AW-1:0] a;
    w_ready = 1'b1;
    dma_wr_addr = 14'h155;
    dma_wr_data = {4{32'hDEADBEEF}};
    dma_wr_valid = 1'b1;
    clear_logs();
    issue_cmd(14'h0, 14'd32, 8'd1);
    wait_done(200, ok);
    first = -1; last = -1;
    foreach (ev_log[i]) if (ev_log[i] == 1) begin if (first < 0) first = i; last = i; end
    run = 0; nw = 0; idle = 0;
    for (int i = first; i <= last && first >= 0; i++) begin
      if (ev_log[i] == 1) run++;
      else if (ev_log[i] == 2) begin
        nw++;
        checks++;
        if (run != 8) begin failures++; $display("FAIL dma_burst%0d: got %0d reads expected 8", nw, run); end
        run = 0;
      end else idle++;
    end
    checks++;
    if (!ok || nw != 3 || idle != 0) begin
      failures++; $display("FAIL dma_pattern: got writes=%0d idle=%0d expected 3 0", nw, idle);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      a = AW'(i);
      if (i >= rd_log.size() || rd_log[i] !== a) bad++;
    end
    checks++;
    if (rd_log.size() != 32 || bad != 0) begin
      failures++; $display("FAIL dma_reads: got n=%0d bad=%0d expected 32 0", rd_log.size(), bad);
    end
    @(negedge clk);
    checks++;
    if (buf_wr_en !== 1'b1 || buf_wr_addr !== 14'h155 || buf_wr_data !== {4{32'hDEADBEEF}} || buf_rd_en !== 1'b0) begin
      failures++; $display("FAIL dma_idle_write: got en=%b addr=%0h expected 1 155", buf_wr_en, buf_wr_addr);
    end
    checks++;
    if (both_en != 0) begin failures++; $display("FAIL rd_wr_exclusive: got %0d overlaps expected 0", both_en); end
    @(posedge clk); #1 dma_wr_valid = 1'b0;
  endtask

  task automatic test_len0;
    bit ok;
    clear_logs();
    issue_cmd(14'h20, 14'd0, 8'd3);
    wait_done(20, ok);
    checks++;
    if (!ok || done_cyc.size() != 1 || done_cyc[0] != acc_cyc + 1 || rd_log.size() != 0) begin
      failures++; $display("FAIL len0_done: got pulses=%0d at %0d reads=%0d expected 1 at %0d reads=0",
                           done_cyc.size(), done_cyc[0], rd_log.size(), acc_cyc + 1);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL len0_idle: got ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    w_ready = 1'b1;
    clear_logs();
    issue_cmd(14'h300, 14'd32, 8'd1);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, busy, done, w_valid, buf_rd_en} !== 5'b10000) begin
      failures++; $display("FAIL midreset_clear: got %b expected 10000", {cmd_ready, busy, done, w_valid, buf_rd_en});
    end
    #1 rst_n = 1'b1;
    clear_logs();
    repeat (6) @(posedge clk);
    checks++;
    if (wd_log.size() != 0 || rd_log.size() != 0 || done_cyc.size() != 0) begin
      failures++; $display("FAIL midreset_late_return: got pops=%0d reads=%0d expected 0 0",
                           wd_log.size(), rd_log.size());
    end
    clear_logs();
    issue_cmd(14'h40, 14'd2, 8'd1);
    wait_done(100, ok);
    checks++;
    if (!ok || wd_log.size() != 2 || wd_log[0] !== word_of(14'h40) || wd_log[1] !== word_of(14'h41) ||
        wl_log[0] !== 1'b0 || wl_log[1] !== 1'b1) begin
      failures++; $display("FAIL midreset_recover: got words=%0d first=%0h expected 2 %0h",
                           wd_log.size(), wd_log[0], word_of(14'h40));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_repeat();
    test_stall();
    test_dma_arb();
    test_len0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
